// File: rtl/interface_permw_n.sv
// rtl/interface_permw_n.sv - N-lane source select + lane permutation with 2-stage elastic output
// Stage 1 captures lanes and per-beat config; stage 2 registers the permuted lanes into Q.
module interface_permw_n #(
  parameter int DW = 64,
  parameter int LANES = 4,
  localparam int LW = $clog2(LANES)
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                SEL_EXTN,
  input  logic [1:0]          MODE,
  input  logic [LW-1:0]       ROT,
  input  logic                ALT,
  input  logic                SOF,
  input  logic                VALID_EXTN,
  input  logic                VALID_HRMF,
  input  logic [LANES*DW-1:0] D_EXTN,
  input  logic [LANES*DW-1:0] D_HRMF,
  output logic                READY_IN,
  output logic                VALID_OUT,
  input  logic                READY_OUT,
  output logic [LANES*DW-1:0] Q
);

  logic                r_s1_valid;
  logic [LANES*DW-1:0] r_s1_data;
  logic [1:0]          r_s1_mode;
  logic [LW-1:0]       r_s1_rot;
  logic                r_s1_p;
  logic                r_s2_valid;
  logic [LANES*DW-1:0] r_q;
  logic                r_parity;

  logic                w_vld_in;
  logic [LANES*DW-1:0] w_d_in;
  logic                w_adv1;
  logic                w_adv2;
  logic                w_accept;
  logic                w_parity_eff;
  logic                w_p;
  logic [LANES*DW-1:0] w_perm;

  assign w_vld_in     = SEL_EXTN ? VALID_HRMF : VALID_EXTN;
  assign w_d_in       = SEL_EXTN ? D_HRMF : D_EXTN;
  assign w_adv2       = !r_s2_valid || READY_OUT;
  assign w_adv1       = !r_s1_valid || w_adv2;
  assign w_accept     = w_vld_in && w_adv1;
  assign w_parity_eff = SOF ? 1'b0 : r_parity;
  assign w_p          = !ALT || w_parity_eff;

  assign READY_IN  = w_adv1;
  assign VALID_OUT = r_s2_valid;
  assign Q         = r_q;

  // Source lane index feeding output lane idx; identity when the beat is not permuted.
  function automatic logic [LW-1:0] f_src(input logic [LW-1:0] idx, input logic [1:0] mode,
                                          input logic [LW-1:0] rot, input logic p);
    logic [LW-1:0] r;
    r = idx;
    if (p) begin
      case (mode)
        2'd1:    r = idx ^ LW'(1);
        2'd2:    r = idx + rot;
        2'd3:    for (int b = 0; b < LW; b++) r[b] = idx[LW-1-b];
        default: r = idx;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    w_perm = '0;
    for (int i = 0; i < LANES; i++) begin
      w_perm[i*DW +: DW] = r_s1_data[int'(f_src(LW'(i), r_s1_mode, r_s1_rot, r_s1_p))*DW +: DW];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= 2'd0;
      r_s1_rot   <= '0;
      r_s1_p     <= 1'b0;
      r_s2_valid <= 1'b0;
      r_q        <= '0;
      r_parity   <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_data <= w_d_in;
          r_s1_mode <= MODE;
          r_s1_rot  <= ROT;
          r_s1_p    <= w_p;
        end
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_q <= w_perm;
      end
      if (w_accept) r_parity <= ~w_parity_eff;
    end
  end

endmodule

// File: tb/tb_interface_permw_n.sv
// tb/tb_interface_permw_n.sv - directed and random checks of interface_permw_n against a lane-index model
// Two instances (4 lanes x 64b, 8 lanes x 16b) share all control signals.
module tb_interface_permw_n;

  typedef struct {
    logic [255:0] q4;
    logic [127:0] q8;
    int           acc;
  } item_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         sel, alt, sof, ve, vh, ro;
  logic [1:0]   mode;
  logic [2:0]   rot;
  logic [255:0] d4e, d4h, q4;
  logic [127:0] d8e, d8h, q8;
  logic         ri4, vo4, ri8, vo8;

  item_t        sb[$];
  logic [255:0] cap4[$];
  int           par, cyc, total, bad;
  bit           a;
  int           n, k;

  always #5 clk = ~clk;

  interface_permw_n #(.DW(64), .LANES(4)) u_dut4 (
    .CLK(clk), .RSTN(rstn), .SEL_EXTN(sel), .MODE(mode), .ROT(rot[1:0]), .ALT(alt), .SOF(sof),
    .VALID_EXTN(ve), .VALID_HRMF(vh), .D_EXTN(d4e), .D_HRMF(d4h),
    .READY_IN(ri4), .VALID_OUT(vo4), .READY_OUT(ro), .Q(q4));

  interface_permw_n #(.DW(16), .LANES(8)) u_dut8 (
    .CLK(clk), .RSTN(rstn), .SEL_EXTN(sel), .MODE(mode), .ROT(rot), .ALT(alt), .SOF(sof),
    .VALID_EXTN(ve), .VALID_HRMF(vh), .D_EXTN(d8e), .D_HRMF(d8h),
    .READY_IN(ri8), .VALID_OUT(vo8), .READY_OUT(ro), .Q(q8));

  function automatic int src_idx(int lanes, int md, int rt, bit p, int i);
    int lw, r, x;
    if (!p) return i;
    case (md)
      1: return i ^ 1;
      2: return (i + rt) % lanes;
      3: begin
        lw = $clog2(lanes); x = i; r = 0;
        for (int b = 0; b < lw; b++) begin r = r * 2 + x % 2; x = x / 2; end
        return r;
      end
      default: return i;
    endcase
  endfunction

  function automatic logic [255:0] perm4(logic [255:0] s, int md, int rt, bit p);
    logic [255:0] r;
    for (int i = 0; i < 4; i++) r[i*64 +: 64] = s[src_idx(4, md, rt, p, i)*64 +: 64];
    return r;
  endfunction

  function automatic logic [127:0] perm8(logic [127:0] s, int md, int rt, bit p);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = s[src_idx(8, md, rt, p, i)*16 +: 16];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step(output bit acc);
    bit    er, ev, pop, peff, p;
    item_t it;
    @(negedge clk);
    er = (sb.size() < 2) || ro;
    ev = (sb.size() > 0) && (sb[0].acc <= cyc - 2);
    chk("ready_in4", 256'(ri4), 256'(er));
    chk("ready_in8", 256'(ri8), 256'(er));
    chk("valid_out4", 256'(vo4), 256'(ev));
    chk("valid_out8", 256'(vo8), 256'(ev));
    if (ev) begin
      chk("q4", q4, sb[0].q4);
      chk("q8", 256'(q8), 256'(sb[0].q8));
    end
    acc = (sel ? vh : ve) && er;
    pop = ev && ro;
    if (acc) begin
      peff = sof ? 1'b0 : par[0];
      p = !alt || peff;
      par = peff ? 0 : 1;
      it.q4 = perm4(sel ? d4h : d4e, mode, rot % 4, p);
      it.q8 = perm8(sel ? d8h : d8e, mode, rot % 8, p);
      it.acc = cyc;
    end
    if (pop) begin
      cap4.push_back(q4);
      void'(sb.pop_front());
    end
    if (acc) sb.push_back(it);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic lanes_idx();
    for (int i = 0; i < 4; i++) d4e[i*64 +: 64] = 64'(i);
    for (int i = 0; i < 8; i++) d8e[i*16 +: 16] = 16'(i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; par = 0; cyc = 0;
    rstn = 1'b0; sel = 0; alt = 0; sof = 0; ve = 0; vh = 0; ro = 1; mode = 0; rot = 0;
    d4e = '0; d4h = '0; d8e = '0; d8h = '0;
    #12;
    chk("reset_valid", 256'(vo4), 256'(0));
    chk("reset_q", q4, 256'(0));
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;

    // Pair swap on 4 lanes
    lanes_idx(); mode = 1; ve = 1;
    step(a);
    ve = 0;
    step(a);
    chk("mode1_q4", q4, {64'd2, 64'd3, 64'd0, 64'd1});
    step(a);

    // Non-selected valid is ignored
    vh = 1;
    for (int i = 0; i < 4; i++) step(a);
    chk("hrmf_ignored", 256'(vo4), 256'(0));
    vh = 0;

    // Rotate by 3
    d4e = {64'hD, 64'hC, 64'hB, 64'hA}; mode = 2; rot = 3; ve = 1;
    step(a);
    ve = 0;
    step(a);
    chk("rot3_q4", q4, {64'hC, 64'hB, 64'hA, 64'hD});
    step(a);

    // Bit-reverse on 8 lanes
    lanes_idx(); mode = 3; ve = 1;
    step(a);
    ve = 0;
    step(a);
    chk("bitrev_q8", 256'(q8), 256'({16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0}));
    step(a);

    // Alternate-beat permute with SOF on beats 0 and 2
    cap4.delete();
    alt = 1; mode = 1; ve = 1;
    for (int b = 0; b < 4; b++) begin
      sof = (b == 0 || b == 2);
      step(a);
    end
    sof = 0; ve = 0;
    for (int i = 0; i < 3; i++) step(a);
    chk("alt_count", 256'(cap4.size()), 256'(4));
    for (int b = 0; b < 4 && b < cap4.size(); b++)
      chk("alt_beat", cap4[b], b[0] ? {64'd2, 64'd3, 64'd0, 64'd1} : {64'd3, 64'd2, 64'd1, 64'd0});
    alt = 0;

    // Back-pressure: stall 5 cycles during a stream of beats 1..10
    cap4.delete();
    mode = 0; n = 1; k = 0;
    while (n <= 10 && k < 100) begin
      ro = !(k >= 2 && k < 7);
      for (int i = 0; i < 4; i++) d4e[i*64 +: 64] = 64'(n);
      for (int i = 0; i < 8; i++) d8e[i*16 +: 16] = 16'(n);
      ve = 1;
      step(a);
      if (a) n++;
      k++;
    end
    chk("bp_all_sent", 256'(n), 256'(11));
    ve = 0; ro = 1;
    for (int i = 0; i < 4; i++) step(a);
    chk("bp_count", 256'(cap4.size()), 256'(10));
    for (int j = 0; j < 10 && j < cap4.size(); j++)
      chk("bp_order", 256'(cap4[j][63:0]), 256'(j + 1));

    // Random per-beat source/mode/config with random back-pressure
    for (int c = 0; c < 300; c++) begin
      sel = 1'($urandom); mode = 2'($urandom); rot = 3'($urandom); alt = 1'($urandom);
      sof = ($urandom_range(0, 7) == 0); ve = ($urandom_range(0, 3) != 0);
      vh = ($urandom_range(0, 3) != 0); ro = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 8; j++) begin d4e[j*32 +: 32] = $urandom; d4h[j*32 +: 32] = $urandom; end
      for (int j = 0; j < 4; j++) begin d8e[j*32 +: 32] = $urandom; d8h[j*32 +: 32] = $urandom; end
      step(a);
    end

    // Reset with two beats in flight
    sel = 0; alt = 0; sof = 0; vh = 0; mode = 1; ro = 0; ve = 1;
    ro = 1; ve = 0;
    for (int i = 0; i < 3; i++) step(a);
    ro = 0; ve = 1;
    step(a); step(a);
    ve = 0;
    #3 rstn = 1'b0;
    #1;
    chk("rst_valid4", 256'(vo4), 256'(0));
    chk("rst_q4", q4, 256'(0));
    chk("rst_valid8", 256'(vo8), 256'(0));
    chk("rst_q8", 256'(q8), 256'(0));
    sb.delete(); par = 0;
    step(a);
    rstn = 1'b1; ro = 1;
    lanes_idx(); ve = 1;
    step(a);
    ve = 0;
    step(a);
    chk("post_rst_valid", 256'(vo4), 256'(1));
    chk("post_rst_q4", q4, {64'd2, 64'd3, 64'd0, 64'd1});
    step(a); step(a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
